// File: rtl/noc_box.sv
// NOC target device: decodes byte-serial READ/WRITE requests into a 256-byte register memory and
// returns responses. Define NOC_BOX_WRESP_EN to have each accepted WRITE answered with WRITE_RESP.
module noc_box #(
  parameter logic [7:0] DEV_ID = 8'h40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       noc_to_dev_ctl,
  input  logic [7:0] noc_to_dev_data,
  output logic       noc_from_dev_ctl,
  output logic [7:0] noc_from_dev_data
);

  localparam logic [2:0] CMD_READ       = 3'd1;
  localparam logic [2:0] CMD_READ_RESP  = 3'd2;
  localparam logic [2:0] CMD_WRITE      = 3'd3;
  localparam logic [2:0] CMD_WRITE_RESP = 3'd4;

  typedef enum logic [2:0] {R_IDLE, R_DEST, R_SRC, R_ADDR, R_WDATA, R_SKIP} rx_state_e;
  typedef enum logic [2:0] {T_IDLE, T_CMD, T_DEST, T_SRC, T_DATA, T_STATUS} tx_state_e;

  rx_state_e  rx_state_q, rx_state_d;
  logic       rx_write_q, rx_write_d;
  logic [1:0] alen_q, alen_d;
  logic [2:0] dlen_q, dlen_d;
  logic [7:0] src_q, src_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] idx_q, idx_d;

  tx_state_e  tx_state_q, tx_state_d;
  logic       tx_write_q, tx_write_d;
  logic [2:0] tx_dlen_q, tx_dlen_d;
  logic [7:0] tx_dest_q, tx_dest_d;
  logic [7:0] tx_idx_q, tx_idx_d;
  logic [7:0] tx_cnt_q, tx_cnt_d;

  logic [7:0] mem_q [256];
  logic       mem_we;
  logic [7:0] mem_waddr, mem_wdata;

  logic       tx_start, tx_start_write;
  logic [7:0] tx_start_idx;
  logic       cmd_start;
  logic [7:0] alen_last, dlen_last, tx_dlen_last;

  assign alen_last    = (8'd1 << alen_q) - 8'd1;
  assign dlen_last    = (8'd1 << dlen_q) - 8'd1;
  assign tx_dlen_last = (8'd1 << tx_dlen_q) - 8'd1;

  // Commands are only taken while the transmitter is idle; anything else is dropped.
  assign cmd_start = noc_to_dev_ctl && (tx_state_q == T_IDLE) &&
                     ((noc_to_dev_data[2:0] == CMD_READ) || (noc_to_dev_data[2:0] == CMD_WRITE));

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_write_d     = rx_write_q;
    alen_d         = alen_q;
    dlen_d         = dlen_q;
    src_d          = src_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    mem_we         = 1'b0;
    mem_waddr      = idx_q;
    mem_wdata      = noc_to_dev_data;
    tx_start       = 1'b0;
    tx_start_write = 1'b0;
    tx_start_idx   = idx_q;
    if (noc_to_dev_ctl) begin
      // Any ctl byte ends the packet in flight and is decoded afresh.
      rx_state_d = R_IDLE;
      if (cmd_start) begin
        rx_state_d = R_DEST;
        rx_write_d = (noc_to_dev_data[2:0] == CMD_WRITE);
        alen_d     = noc_to_dev_data[7:6];
        dlen_d     = noc_to_dev_data[5:3];
      end
    end else begin
      case (rx_state_q)
        R_DEST: rx_state_d = (noc_to_dev_data == DEV_ID) ? R_SRC : R_SKIP;
        R_SRC: begin
          src_d      = noc_to_dev_data;
          cnt_d      = 8'd0;
          rx_state_d = R_ADDR;
        end
        R_ADDR: begin
          if (cnt_q == 8'd0) idx_d = noc_to_dev_data;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == alen_last) begin
            cnt_d = 8'd0;
            if (rx_write_q) begin
              rx_state_d = R_WDATA;
            end else begin
              rx_state_d   = R_IDLE;
              tx_start     = 1'b1;
              tx_start_idx = (cnt_q == 8'd0) ? noc_to_dev_data : idx_q;
            end
          end
        end
        R_WDATA: begin
          mem_we = 1'b1;
          idx_d  = idx_q + 8'd1;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == dlen_last) begin
            rx_state_d = R_IDLE;
`ifdef NOC_BOX_WRESP_EN
            tx_start       = 1'b1;
            tx_start_write = 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_state_d        = tx_state_q;
    tx_write_d        = tx_write_q;
    tx_dlen_d         = tx_dlen_q;
    tx_dest_d         = tx_dest_q;
    tx_idx_d          = tx_idx_q;
    tx_cnt_d          = tx_cnt_q;
    noc_from_dev_ctl  = 1'b1;
    noc_from_dev_data = 8'h00;
    case (tx_state_q)
      T_IDLE: begin
        if (tx_start) begin
          tx_state_d = T_CMD;
          tx_write_d = tx_start_write;
          tx_dlen_d  = dlen_q;
          tx_dest_d  = src_q;
          tx_idx_d   = tx_start_idx;
          tx_cnt_d   = 8'd0;
        end
      end
      T_CMD: begin
        noc_from_dev_data = tx_write_q ? {5'b00000, CMD_WRITE_RESP}
                                       : {2'b00, tx_dlen_q, CMD_READ_RESP};
        tx_state_d = T_DEST;
      end
      T_DEST: begin
        noc_from_dev_ctl  = 1'b0;
        noc_from_dev_data = tx_dest_q;
        tx_state_d        = T_SRC;
      end
      T_SRC: begin
        noc_from_dev_ctl  = 1'b0;
        noc_from_dev_data = DEV_ID;
        tx_state_d        = tx_write_q ? T_STATUS : T_DATA;
      end
      T_DATA: begin
        // Memory is sampled as each byte goes out.
        noc_from_dev_ctl  = 1'b0;
        noc_from_dev_data = mem_q[tx_idx_q];
        tx_idx_d          = tx_idx_q + 8'd1;
        tx_cnt_d          = tx_cnt_q + 8'd1;
        if (tx_cnt_q == tx_dlen_last) tx_state_d = T_IDLE;
      end
      T_STATUS: begin
        noc_from_dev_ctl  = 1'b0;
        noc_from_dev_data = 8'h00;
        tx_state_d        = T_IDLE;
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      rx_write_q <= 1'b0;
      alen_q     <= 2'd0;
      dlen_q     <= 3'd0;
      src_q      <= 8'h00;
      cnt_q      <= 8'h00;
      idx_q      <= 8'h00;
      tx_state_q <= T_IDLE;
      tx_write_q <= 1'b0;
      tx_dlen_q  <= 3'd0;
      tx_dest_q  <= 8'h00;
      tx_idx_q   <= 8'h00;
      tx_cnt_q   <= 8'h00;
      for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
    end else begin
      rx_state_q <= rx_state_d;
      rx_write_q <= rx_write_d;
      alen_q     <= alen_d;
      dlen_q     <= dlen_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tx_state_q <= tx_state_d;
      tx_write_q <= tx_write_d;
      tx_dlen_q  <= tx_dlen_d;
      tx_dest_q  <= tx_dest_d;
      tx_idx_q   <= tx_idx_d;
      tx_cnt_q   <= tx_cnt_d;
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_noc_box.sv
// Bench for noc_box: packet-level reference model checked every cycle, literal response pins,
// then randomized traffic with resets, aborts, foreign IDs and overlapping commands.
module tb_noc_box;
  localparam logic [8:0] NOP = 9'h100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       to_ctl = 1'b1;
  logic [7:0] to_data = 8'h00;
  logic       from_ctl;
  logic [7:0] from_data;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  noc_box dut (
    .clk              (clk),
    .reset            (reset),
    .noc_to_dev_ctl   (to_ctl),
    .noc_to_dev_data  (to_data),
    .noc_from_dev_ctl (from_ctl),
    .noc_from_dev_data(from_data)
  );

  // Reference model: memory image, bytes of the packet being collected, queued response bytes.
  logic [7:0] m_mem [256];
  logic [7:0] m_pkt [$];
  logic [8:0] m_out_q [$];
  logic [8:0] m_exp = NOP;
  bit         m_active = 0;
  bit         m_valid = 0;

  logic [8:0] log_q [$];
  bit         log_en = 0;
  logic [8:0] lit [8];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got ctl=%0b data=%02h, required ctl=%0b data=%02h (t=%0t)",
                  name, act[8], act[7:0], expv[8], expv[7:0], $time);
  endtask

  task automatic model_step(input logic rst, input logic c, input logic [7:0] d);
    int a, n, dl;
    logic [7:0] c0, ix;
    bit busy;
    if (rst) begin
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      m_pkt.delete();
      m_out_q.delete();
      m_active = 0;
      m_exp = NOP;
      m_valid = 1;
      return;
    end
    busy = (m_exp != NOP);  // a response byte is on the wire this cycle
    if (c) begin
      m_pkt.delete();
      m_active = 0;
      if (!busy && (d[2:0] == 3'd1 || d[2:0] == 3'd3)) begin
        m_active = 1;
        m_pkt.push_back(d);
      end
    end else if (m_active) begin
      m_pkt.push_back(d);
      n  = m_pkt.size();
      c0 = m_pkt[0];
      a  = 1 << c0[7:6];
      dl = 1 << c0[5:3];
      if (n == 2 && d != 8'h40) begin
        m_active = 0;
      end else if (c0[2:0] == 3'd1 && n == 3 + a) begin
        m_out_q.push_back({1'b1, 2'b00, c0[5:3], 3'b010});
        m_out_q.push_back({1'b0, m_pkt[2]});
        m_out_q.push_back({1'b0, 8'h40});
        for (int k = 0; k < dl; k++) begin
          ix = m_pkt[3] + 8'(k);
          m_out_q.push_back({1'b0, m_mem[ix]});
        end
        m_active = 0;
      end else if (c0[2:0] == 3'd3 && n > 3 + a) begin
        ix = m_pkt[3] + 8'(n - 4 - a);
        m_mem[ix] = d;
        if (n == 3 + a + dl) begin
          m_active = 0;
`ifdef NOC_BOX_WRESP_EN
          m_out_q.push_back(9'h104);
          m_out_q.push_back({1'b0, m_pkt[2]});
          m_out_q.push_back({1'b0, 8'h40});
          m_out_q.push_back(9'h000);
`endif
        end
      end
    end
    m_exp = (m_out_q.size() != 0) ? m_out_q.pop_front() : NOP;
  endtask

  task automatic send(input logic c, input logic [7:0] d);
    to_ctl  = c;
    to_data = d;
    @(posedge clk);
    model_step(reset, c, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b1, 8'h00);
  endtask

  // Compares the first non-NOP stretch of the log with lit[0..n-1] followed by NOP.
  task automatic check_log(input string name, input int n);
    int i;
    logic [8:0] act;
    i = 0;
    while (i < log_q.size() && log_q[i] == NOP) i++;
    if (n == 0) begin
      act = (i < log_q.size()) ? log_q[i] : NOP;
      check(name, act, NOP);
    end else begin
      for (int j = 0; j <= n; j++) begin
        act = (i + j < log_q.size()) ? log_q[i + j] : 9'bx;
        check(name, act, (j < n) ? lit[j] : NOP);
      end
    end
    log_q.delete();
  endtask

  task automatic set_read_lit(input logic [7:0] cmd_resp, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3);
    lit[0] = {1'b1, cmd_resp};
    lit[1] = 9'h091;
    lit[2] = 9'h040;
    lit[3] = {1'b0, d0};
    lit[4] = {1'b0, d1};
    lit[5] = {1'b0, d2};
    lit[6] = {1'b0, d3};
  endtask

  task automatic check_wresp(input string name);
`ifdef NOC_BOX_WRESP_EN
    lit[0] = 9'h104;
    lit[1] = 9'h091;
    lit[2] = 9'h040;
    lit[3] = 9'h000;
    check_log(name, 4);
`else
    check_log(name, 0);
`endif
  endtask

  always @(negedge clk) begin
    if (m_valid) check("cycle", {from_ctl, from_data}, m_exp);
    if (log_en) log_q.push_back({from_ctl, from_data});
  end

  initial begin
    send(1'b1, 8'h00);
    send(1'b1, 8'h00);
    reset = 1'b0;
    log_en = 1;
    log_q.delete();
    idle(6);
    check_log("idle_nop", 0);

    // READ 0x10 after reset returns zero
    send(1'b1, 8'h01); send(1'b0, 8'h40); send(1'b0, 8'h91); send(1'b0, 8'h10);
    idle(8);
    set_read_lit(8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
    check_log("read_after_reset", 4);

    // WRITE AA BB CC DD at 0x05, then read back
    send(1'b1, 8'h13); send(1'b0, 8'h40); send(1'b0, 8'h91); send(1'b0, 8'h05);
    send(1'b0, 8'hAA); send(1'b0, 8'hBB); send(1'b0, 8'hCC); send(1'b0, 8'hDD);
    idle(8);
    check_wresp("write_resp");
    send(1'b1, 8'h11); send(1'b0, 8'h40); send(1'b0, 8'h91); send(1'b0, 8'h05);
    idle(12);
    set_read_lit(8'h12, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    check_log("read_back", 7);

    // Index wrap 0xFF -> 0x00
    send(1'b1, 8'h0B); send(1'b0, 8'h40); send(1'b0, 8'h91); send(1'b0, 8'hFF);
    send(1'b0, 8'h11); send(1'b0, 8'h22);
    idle(8);
    check_wresp("wrap_write");
    send(1'b1, 8'h01); send(1'b0, 8'h40); send(1'b0, 8'h91); send(1'b0, 8'hFF);
    idle(8);
    set_read_lit(8'h02, 8'h11, 8'h00, 8'h00, 8'h00);
    check_log("wrap_ff", 4);
    send(1'b1, 8'h01); send(1'b0, 8'h40); send(1'b0, 8'h91); send(1'b0, 8'h00);
    idle(8);
    set_read_lit(8'h02, 8'h22, 8'h00, 8'h00, 8'h00);
    check_log("wrap_00", 4);

    // Foreign ID is ignored
    send(1'b1, 8'h03); send(1'b0, 8'h41); send(1'b0, 8'h91); send(1'b0, 8'h05); send(1'b0, 8'h55);
    idle(8);
    check_log("other_id_silent", 0);
    send(1'b1, 8'h01); send(1'b0, 8'h40); send(1'b0, 8'h91); send(1'b0, 8'h05);
    idle(8);
    set_read_lit(8'h02, 8'hAA, 8'h00, 8'h00, 8'h00);
    check_log("other_id_mem", 4);

    // Abort: two of four data bytes, then a READ command cuts in
    send(1'b1, 8'h13); send(1'b0, 8'h40); send(1'b0, 8'h91); send(1'b0, 8'h20);
    send(1'b0, 8'h01); send(1'b0, 8'h02);
    send(1'b1, 8'h11); send(1'b0, 8'h40); send(1'b0, 8'h91); send(1'b0, 8'h20);
    idle(12);
    set_read_lit(8'h12, 8'h01, 8'h02, 8'h00, 8'h00);
    check_log("abort", 7);

    // Two address bytes, upper one discarded
    send(1'b1, 8'h51); send(1'b0, 8'h40); send(1'b0, 8'h91); send(1'b0, 8'h05); send(1'b0, 8'h7F);
    idle(12);
    set_read_lit(8'h12, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    check_log("alen2", 7);
    log_en = 0;

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      int kind, alc, dlc, body, gap;
      logic [7:0] cmd, dest, src, addr0, b;
      if ($urandom_range(0, 99) < 3) begin
        reset = 1'b1;
        send(1'b1, 8'($urandom));
        reset = 1'b0;
      end
      kind = $urandom_range(0, 19);
      alc  = $urandom_range(0, 3);
      dlc  = ($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, 3);
      cmd  = {2'(alc), 3'(dlc), (kind < 9) ? 3'd1 : (kind < 18) ? 3'd3 : (kind == 18) ? 3'd2 : 3'd5};
      dest = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h40;
      src  = 8'($urandom);
      addr0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 31));
      body = 2 + (1 << alc) + ((cmd[2:0] == 3'd3) ? (1 << dlc) : 0);
      if ($urandom_range(0, 9) == 0) body = $urandom_range(0, body - 1);
      send(1'b1, cmd);
      for (int k = 0; k < body; k++) begin
        b = (k == 0) ? dest : (k == 1) ? src : (k == 2) ? addr0 : 8'($urandom);
        send(1'b0, b);
      end
      gap = $urandom_range(0, 6);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 7) == 0) send(1'b0, 8'($urandom));
        else send(1'b1, 8'h00);
      end
    end
    idle(140);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
